// File: rtl/fpu_req_arbiter_if.sv
// rtl/fpu_req_arbiter_if.sv - request, FPU issue/return and response bundle for fpu_req_arbiter
interface fpu_req_arbiter_if #(
  parameter int NUM_REQ         = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int PRECISION       = 32,
  parameter int MAX_OUTSTANDING = 4
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  // requester side
  logic [NUM_REQ-1:0]            I_Req_Valid;
  logic [NUM_REQ-1:0]            O_Req_Ready;
  logic [NUM_REQ-1:0]            I_Req_Op1_Sign;
  logic [NUM_REQ-1:0]            I_Req_Op2_Sign;
  logic [NUM_REQ*DATA_WIDTH-1:0] I_Req_Op1_Int;
  logic [NUM_REQ*DATA_WIDTH-1:0] I_Req_Op1_Fract;
  logic [NUM_REQ*DATA_WIDTH-1:0] I_Req_Op2_Int;
  logic [NUM_REQ*DATA_WIDTH-1:0] I_Req_Op2_Fract;
  logic [NUM_REQ*3-1:0]          I_Req_Operation;

  // FPU issue side
  logic                  O_Fpu_Op_Valid;
  logic                  O_Fpu_Op1_Sign;
  logic                  O_Fpu_Op2_Sign;
  logic [DATA_WIDTH-1:0] O_Fpu_Op1_Int;
  logic [DATA_WIDTH-1:0] O_Fpu_Op1_Fract;
  logic [DATA_WIDTH-1:0] O_Fpu_Op2_Int;
  logic [DATA_WIDTH-1:0] O_Fpu_Op2_Fract;
  logic [2:0]            O_Fpu_Operation;

  // FPU return side
  logic                 I_Fpu_Valid;
  logic [PRECISION-1:0] I_Fpu_Result;

  // response and status
  logic                 O_Rsp_Valid;
  logic [ID_W-1:0]      O_Rsp_Id;
  logic [PRECISION-1:0] O_Rsp_Result;
  logic [CNT_W-1:0]     O_Outstanding;
  logic                 O_Err;

  modport master (
    output I_Req_Valid, I_Req_Op1_Sign, I_Req_Op2_Sign,
           I_Req_Op1_Int, I_Req_Op1_Fract, I_Req_Op2_Int, I_Req_Op2_Fract,
           I_Req_Operation, I_Fpu_Valid, I_Fpu_Result,
    input  O_Req_Ready, O_Fpu_Op_Valid, O_Fpu_Op1_Sign, O_Fpu_Op2_Sign,
           O_Fpu_Op1_Int, O_Fpu_Op1_Fract, O_Fpu_Op2_Int, O_Fpu_Op2_Fract,
           O_Fpu_Operation, O_Rsp_Valid, O_Rsp_Id, O_Rsp_Result,
           O_Outstanding, O_Err
  );

  modport slave (
    input  I_Req_Valid, I_Req_Op1_Sign, I_Req_Op2_Sign,
           I_Req_Op1_Int, I_Req_Op1_Fract, I_Req_Op2_Int, I_Req_Op2_Fract,
           I_Req_Operation, I_Fpu_Valid, I_Fpu_Result,
    output O_Req_Ready, O_Fpu_Op_Valid, O_Fpu_Op1_Sign, O_Fpu_Op2_Sign,
           O_Fpu_Op1_Int, O_Fpu_Op1_Fract, O_Fpu_Op2_Int, O_Fpu_Op2_Fract,
           O_Fpu_Operation, O_Rsp_Valid, O_Rsp_Id, O_Rsp_Result,
           O_Outstanding, O_Err
  );
endinterface

// File: rtl/fpu_req_arbiter.sv
// rtl/fpu_req_arbiter.sv - round-robin FPU request arbiter with in-order result ID tracking
// The interface instance must carry the same parameter values as this module.
module fpu_req_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int PRECISION       = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              I_Clk,
  input  logic              I_nReset,
  fpu_req_arbiter_if.slave  bus
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  logic [ID_W-1:0]  last_grant;
  logic [ID_W-1:0]  sel;
  logic             found;
  logic             can_issue;
  logic             push;
  logic             pop;
  logic             full;
  logic [NUM_REQ-1:0] req_ready;

  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [ID_W-1:0]  id_mem [MAX_OUTSTANDING];

  logic                  fpu_op_valid;
  logic                  fpu_op1_sign;
  logic                  fpu_op2_sign;
  logic [DATA_WIDTH-1:0] fpu_op1_int;
  logic [DATA_WIDTH-1:0] fpu_op1_fract;
  logic [DATA_WIDTH-1:0] fpu_op2_int;
  logic [DATA_WIDTH-1:0] fpu_op2_fract;
  logic [2:0]            fpu_operation;

  logic                 rsp_valid;
  logic [ID_W-1:0]      rsp_id;
  logic [PRECISION-1:0] rsp_result;
  logic                 err;

  // A full FIFO can still accept a push when a result retires the head this cycle
  assign full      = (count == CNT_W'(MAX_OUTSTANDING));
  assign pop       = bus.I_Fpu_Valid && (count != '0);
  assign can_issue = !full || pop;
  assign push      = found && can_issue;

  // Round-robin search starting one past the last granted requester, wrapping modulo NUM_REQ
  always_comb begin
    logic [ID_W:0] cand;
    sel   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, last_grant} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (!found && bus.I_Req_Valid[cand[ID_W-1:0]]) begin
        found = 1'b1;
        sel   = cand[ID_W-1:0];
      end
    end
  end

  // Ready goes only to the selected requester, and never while reset is held
  always_comb begin
    req_ready = '0;
    if (I_nReset && push) begin
      req_ready[sel] = 1'b1;
    end
  end

  // Grant pointer, FIFO pointers and in-flight count
  always_ff @(posedge I_Clk or negedge I_nReset) begin
    if (!I_nReset) begin
      last_grant <= ID_W'(NUM_REQ - 1);
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      if (push) begin
        last_grant <= sel;
        wr_ptr     <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ID storage needs no reset: entries are only read when count says they are valid
  always_ff @(posedge I_Clk) begin
    if (push) begin
      id_mem[wr_ptr] <= sel;
    end
  end

  // Issue register: operands captured from the granted slice; data holds between issues
  always_ff @(posedge I_Clk or negedge I_nReset) begin
    if (!I_nReset) begin
      fpu_op_valid  <= 1'b0;
      fpu_op1_sign  <= 1'b0;
      fpu_op2_sign  <= 1'b0;
      fpu_op1_int   <= '0;
      fpu_op1_fract <= '0;
      fpu_op2_int   <= '0;
      fpu_op2_fract <= '0;
      fpu_operation <= '0;
    end else begin
      fpu_op_valid <= push;
      if (push) begin
        fpu_op1_sign  <= bus.I_Req_Op1_Sign[sel];
        fpu_op2_sign  <= bus.I_Req_Op2_Sign[sel];
        fpu_op1_int   <= bus.I_Req_Op1_Int[sel*DATA_WIDTH +: DATA_WIDTH];
        fpu_op1_fract <= bus.I_Req_Op1_Fract[sel*DATA_WIDTH +: DATA_WIDTH];
        fpu_op2_int   <= bus.I_Req_Op2_Int[sel*DATA_WIDTH +: DATA_WIDTH];
        fpu_op2_fract <= bus.I_Req_Op2_Fract[sel*DATA_WIDTH +: DATA_WIDTH];
        fpu_operation <= bus.I_Req_Operation[sel*3 +: 3];
      end
    end
  end

  // Response register: tag each FPU result with the oldest in-flight ID; flag orphan results
  always_ff @(posedge I_Clk or negedge I_nReset) begin
    if (!I_nReset) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      err        <= 1'b0;
    end else begin
      rsp_valid <= pop;
      if (pop) begin
        rsp_id     <= id_mem[rd_ptr];
        rsp_result <= bus.I_Fpu_Result;
      end
      if (bus.I_Fpu_Valid && (count == '0)) begin
        err <= 1'b1;
      end
    end
  end

  assign bus.O_Req_Ready     = req_ready;
  assign bus.O_Fpu_Op_Valid  = fpu_op_valid;
  assign bus.O_Fpu_Op1_Sign  = fpu_op1_sign;
  assign bus.O_Fpu_Op2_Sign  = fpu_op2_sign;
  assign bus.O_Fpu_Op1_Int   = fpu_op1_int;
  assign bus.O_Fpu_Op1_Fract = fpu_op1_fract;
  assign bus.O_Fpu_Op2_Int   = fpu_op2_int;
  assign bus.O_Fpu_Op2_Fract = fpu_op2_fract;
  assign bus.O_Fpu_Operation = fpu_operation;
  assign bus.O_Rsp_Valid     = rsp_valid;
  assign bus.O_Rsp_Id        = rsp_id;
  assign bus.O_Rsp_Result    = rsp_result;
  assign bus.O_Outstanding   = count;
  assign bus.O_Err           = err;
endmodule

// File: tb/tb_fpu_req_arbiter.sv
// tb/tb_fpu_req_arbiter.sv - bench for fpu_req_arbiter with a queue-based reference model
module tb_fpu_req_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int P  = 32;
  localparam int MO = 4;

  logic clk;
  logic rst_n;

  fpu_req_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .PRECISION(P), .MAX_OUTSTANDING(MO)) bus ();

  fpu_req_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .PRECISION(P), .MAX_OUTSTANDING(MO)) dut (
    .I_Clk    (clk),
    .I_nReset (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model state
  int          cyc;
  int          lat;
  int          last_g;
  int          idq[$];
  int          due[$];
  bit          m_err;
  bit          e_opv;
  bit          e_s1, e_s2;
  logic [DW-1:0] e_i1, e_f1, e_i2, e_f2;
  logic [2:0]  e_op;
  bit          e_rv;
  int          e_rid;
  logic [P-1:0] e_rres;
  bit          hold_data;
  bit          hold_res;
  logic [P-1:0] fixed_res;
  int          max_out;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    last_g = N - 1;
    idq.delete();
    due.delete();
    m_err = 0;
    e_opv = 0; e_s1 = 0; e_s2 = 0;
    e_i1 = '0; e_f1 = '0; e_i2 = '0; e_f2 = '0; e_op = '0;
    e_rv = 0; e_rid = 0; e_rres = '0;
  endtask

  task automatic check_outputs();
    chk("op_valid",    bus.O_Fpu_Op_Valid, e_opv);
    chk("op1_sign",    bus.O_Fpu_Op1_Sign, e_s1);
    chk("op2_sign",    bus.O_Fpu_Op2_Sign, e_s2);
    chk("op1_int",     bus.O_Fpu_Op1_Int, e_i1);
    chk("op1_fract",   bus.O_Fpu_Op1_Fract, e_f1);
    chk("op2_int",     bus.O_Fpu_Op2_Int, e_i2);
    chk("op2_fract",   bus.O_Fpu_Op2_Fract, e_f2);
    chk("operation",   bus.O_Fpu_Operation, e_op);
    chk("rsp_valid",   bus.O_Rsp_Valid, e_rv);
    chk("rsp_id",      bus.O_Rsp_Id, e_rid);
    chk("rsp_result",  bus.O_Rsp_Result, e_rres);
    chk("outstanding", bus.O_Outstanding, idq.size());
    chk("err",         bus.O_Err, m_err);
  endtask

  task automatic randomize_data();
    bus.I_Req_Op1_Sign  = N'($urandom);
    bus.I_Req_Op2_Sign  = N'($urandom);
    bus.I_Req_Operation = (N*3)'($urandom);
    for (int k = 0; k < N; k++) begin
      bus.I_Req_Op1_Int[k*DW +: DW]   = $urandom;
      bus.I_Req_Op1_Fract[k*DW +: DW] = $urandom;
      bus.I_Req_Op2_Int[k*DW +: DW]   = $urandom;
      bus.I_Req_Op2_Fract[k*DW +: DW] = $urandom;
    end
  endtask

  // One clock: drive at negedge, check ready before the edge, update model, check outputs after
  task automatic step(input logic [N-1:0] v, input bit force_fpu);
    bit fv;
    int cnt;
    bit can;
    int s;
    logic [N-1:0] exp_ready;
    @(negedge clk);
    bus.I_Req_Valid = v;
    if (!hold_data) randomize_data();
    fv = force_fpu;
    if (due.size() > 0 && due[0] == cyc) begin
      fv = 1;
      void'(due.pop_front());
    end
    bus.I_Fpu_Valid  = fv;
    bus.I_Fpu_Result = hold_res ? fixed_res : P'($urandom);
    #1;
    cnt = idq.size();
    can = (cnt < MO) || (fv && cnt > 0);
    s = -1;
    for (int i = 1; i <= N; i++) begin
      int k;
      k = (last_g + i) % N;
      if (s < 0 && v[k]) s = k;
    end
    exp_ready = '0;
    if (rst_n && s >= 0 && can) exp_ready[s] = 1'b1;
    chk("req_ready", bus.O_Req_Ready, exp_ready);
    @(posedge clk);
    if (rst_n) begin
      e_rv = 0;
      if (fv && cnt > 0) begin
        e_rv   = 1;
        e_rid  = idq.pop_front();
        e_rres = bus.I_Fpu_Result;
      end else if (fv) begin
        m_err = 1;
      end
      e_opv = 0;
      if (s >= 0 && can) begin
        e_opv  = 1;
        idq.push_back(s);
        due.push_back(cyc + 1 + lat);
        last_g = s;
        e_s1 = bus.I_Req_Op1_Sign[s];
        e_s2 = bus.I_Req_Op2_Sign[s];
        e_i1 = bus.I_Req_Op1_Int[s*DW +: DW];
        e_f1 = bus.I_Req_Op1_Fract[s*DW +: DW];
        e_i2 = bus.I_Req_Op2_Int[s*DW +: DW];
        e_f2 = bus.I_Req_Op2_Fract[s*DW +: DW];
        e_op = bus.I_Req_Operation[s*3 +: 3];
      end
    end
    #1;
    check_outputs();
    if (int'(bus.O_Outstanding) > max_out) max_out = int'(bus.O_Outstanding);
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (due.size() == 0 && idq.size() == 0) break;
      step('0, 0);
    end
    chk("drain_outstanding", bus.O_Outstanding, 0);
  endtask

  initial begin
    cyc = 0; lat = 2; hold_data = 0; hold_res = 0; fixed_res = '0; max_out = 0;
    model_reset();
    rst_n = 1'b0;
    bus.I_Req_Valid  = '1;
    bus.I_Fpu_Valid  = 1'b0;
    bus.I_Fpu_Result = '0;
    randomize_data();
    #1;
    // reset state, ready suppressed despite valid requests
    chk("reset_ready", bus.O_Req_Ready, 0);
    check_outputs();
    @(negedge clk);
    bus.I_Req_Valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // single request from requester 2, latency 2
    hold_data = 1; hold_res = 1; fixed_res = 32'h41400000;
    bus.I_Req_Op1_Sign = '0; bus.I_Req_Op2_Sign = '0; bus.I_Req_Operation = '0;
    bus.I_Req_Op1_Int = '0; bus.I_Req_Op1_Fract = '0;
    bus.I_Req_Op2_Int = '0; bus.I_Req_Op2_Fract = '0;
    bus.I_Req_Op1_Int[2*DW +: DW] = 5;
    bus.I_Req_Op2_Int[2*DW +: DW] = 7;
    bus.I_Req_Operation[2*3 +: 3] = 3'd1;
    step(4'b0100, 0);
    chk("t1_op_valid", bus.O_Fpu_Op_Valid, 1);
    chk("t1_op1_int", bus.O_Fpu_Op1_Int, 5);
    chk("t1_op2_int", bus.O_Fpu_Op2_Int, 7);
    chk("t1_operation", bus.O_Fpu_Operation, 1);
    step('0, 0);
    step('0, 0);
    step('0, 0);
    chk("t1_rsp_valid", bus.O_Rsp_Valid, 1);
    chk("t1_rsp_id", bus.O_Rsp_Id, 2);
    chk("t1_rsp_result", bus.O_Rsp_Result, 32'h41400000);
    hold_data = 0; hold_res = 0;
    drain();

    // all requesters valid for 8 cycles, latency 2
    lat = 2; max_out = 0;
    for (int i = 0; i < 8; i++) step(4'b1111, 0);
    drain();
    chk("t2_max_outstanding_le3", (max_out <= 3), 1);

    // latency 6: FIFO fills, ready reopens on the retiring cycle
    lat = 6;
    for (int i = 0; i < 14; i++) step(4'b0010, 0);
    drain();

    // orphan FPU result sets a sticky error
    step('0, 1);
    chk("t4_err_set", bus.O_Err, 1);
    chk("t4_no_rsp", bus.O_Rsp_Valid, 0);
    for (int i = 0; i < 10; i++) step('0, 0);
    chk("t4_err_hold", bus.O_Err, 1);

    // reset with three operations in flight
    lat = 6;
    for (int i = 0; i < 3; i++) step(4'b0010, 0);
    @(negedge clk);
    bus.I_Req_Valid = 4'b1001;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t5_ready_in_reset", bus.O_Req_Ready, 0);
    check_outputs();
    step(4'b1001, 0);
    @(negedge clk);
    bus.I_Req_Valid = '0;
    bus.I_Fpu_Valid = 1'b0;
    rst_n = 1'b1;
    lat = 2;
    step(4'b1001, 0);
    chk("t5_first_grant_r0", bus.O_Fpu_Op_Valid, 1);
    step(4'b1001, 0);
    drain();

    // wrap-around: grant to 3, then 0 and 3 together go 0 then 3
    step(4'b1000, 0);
    step(4'b1001, 0);
    step(4'b1001, 0);
    drain();

    // randomized phases with varying latency
    for (int ph = 0; ph < 4; ph++) begin
      lat = $urandom_range(0, 7);
      for (int i = 0; i < 80; i++) begin
        step(N'($urandom), (idq.size() == 0 && due.size() == 0 && $urandom_range(0, 19) == 0));
      end
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
